// File: rtl/sr_drive_ctrl_pkg.sv
// Shared definitions for the SR flip-flop drive controller.
package sr_drive_ctrl_pkg;

    // Width of the pulse/gap down-counter
    localparam int unsigned CNT_W = 4;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_e;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that times the PULSE and GAP phases. It saturates at zero.
module sr_pulse_timer
    import sr_drive_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; decrement only while non-zero so the count never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// Drives a downstream SR flip-flop with timed S/R pulses, then checks its Q.
module sr_drive_ctrl
    import sr_drive_ctrl_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic ack,
    output logic q_exp,
    output logic err
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             q_exp_q, q_exp_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             busy_q, busy_d;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    sr_pulse_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state, timer control and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        q_exp_d  = q_exp_q;
        err_d    = err_q;
        ack_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = PULSE_LOAD;

        unique case (state_q)
            IDLE: begin
                if (set_req && clr_req) begin
                    // Forbidden combination: flag it, never drive
                    err_d = 1'b1;
                end else if (set_req != clr_req) begin
                    if (set_req == q_exp_q) begin
                        // Already in the requested state: acknowledge without a pulse
                        ack_d = 1'b1;
                    end else begin
                        dir_d    = set_req;
                        state_d  = PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = PULSE_LOAD;
                    end
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            CHECK: begin
                // Feedback is only trusted here, after the settling gap
                q_exp_d = dir_q;
                if (q_fb != dir_q) begin
                    err_d = 1'b1;
                end
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // S and R derive from a single state and direction bit, so they are exclusive
        s_d    = (state_d == PULSE) && dir_d;
        r_d    = (state_d == PULSE) && !dir_d;
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            q_exp_q <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            q_exp_q <= q_exp_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            s_q     <= s_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
        end
    end

    assign s     = s_q;
    assign r     = r_q;
    assign busy  = busy_q;
    assign ack   = ack_q;
    assign q_exp = q_exp_q;
    assign err   = err_q;

endmodule
